l_out_pingpong_buf: RTL and testbench

//  Downstream stage of the L-function block: collects the word-serial L(x)=(x-1)/n result
//  (N words of K bits, LSW first) into one of two banks. Replays each complete frame to the
//  mu-multiply (mod n) stage over a ready/valid stream. Ping-pong banking lets the L stage

---
 rtl/l_out_pingpong_buf_pkg.sv | 12 +
 rtl/l_out_pingpong_buf_if.sv | 25 ++
 rtl/l_out_pingpong_buf_bank.sv | 33 +++
 rtl/l_out_pingpong_buf.sv | 109 ++++++++++
 tb/tb_l_out_pingpong_buf.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/l_out_pingpong_buf_pkg.sv
// rtl/l_out_pingpong_buf_pkg.sv - shared defaults and read-FSM state type for the L-output ping-pong buffer
package l_out_pingpong_buf_pkg;

   localparam int K_DEF = 128;
   localparam int N_DEF = 32;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_SEND = 1'b1
   } rd_state_t;

endpackage

// File: rtl/l_out_pingpong_buf_if.sv
// rtl/l_out_pingpong_buf_if.sv - L-word input side and mu-multiply output stream of the ping-pong buffer
interface l_out_pingpong_buf_if #(
   parameter int K = 128,
   parameter int N = 32
);
   localparam int IDX_W = $clog2(N);

   logic [K-1:0]     l_out;
   logic             l_out_valid;
   logic [K-1:0]     m_data;
   logic             m_valid;
   logic             m_ready;
   logic [IDX_W-1:0] m_idx;
   logic             m_last;

   modport master (
      output l_out, l_out_valid, m_ready,
      input  m_data, m_valid, m_idx, m_last
   );

   modport slave (
      input  l_out, l_out_valid, m_ready,
      output m_data, m_valid, m_idx, m_last
   );
endinterface

// File: rtl/l_out_pingpong_buf_bank.sv
// rtl/l_out_pingpong_buf_bank.sv - one N x K frame bank: flop storage, async read, full flag
module l_buf_bank #(
   parameter int K = 128,
   parameter int N = 32,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [K-1:0]     wdata,
   input  logic             set_full,
   input  logic             clr_full,
   input  logic [IDX_W-1:0] raddr,
   output logic [K-1:0]     rdata,
   output logic             full
);
   logic [K-1:0] mem [N];

   // Data words need no reset; the full flag alone decides what is ever read out.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr)  full <= 1'b0;
      else if (set_full)  full <= 1'b1;
      else if (clr_full)  full <= 1'b0;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/l_out_pingpong_buf.sv
// rtl/l_out_pingpong_buf.sv - collects L(x) frames into two banks and replays each to the mu-multiply stage
module l_out_pingpong_buf
   import l_out_pingpong_buf_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  task_start,
   l_out_pingpong_buf_if.slave   bus,
   output logic                  busy,
   output logic                  err_overflow
);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   rd_state_t        rd_state;
   logic             wr_bank;
   logic             rd_bank;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_addr;
   logic [1:0]       full;
   logic [K-1:0]     rdata [2];
   logic             wr_en;
   logic             wr_last;
   logic             acc;
   logic             rd_done;

   assign wr_en   = bus.l_out_valid & ~task_start & ~full[wr_bank];
   assign wr_last = wr_en & (wr_idx == LAST);
   assign acc     = bus.m_valid & bus.m_ready;
   assign rd_done = (rd_state == RD_SEND) & acc & (bus.m_idx == LAST);
   // Next word to present: word 0 when starting a frame, else the one after m_idx.
   assign rd_addr = (rd_state == RD_SEND) ? bus.m_idx + 1'b1 : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      l_buf_bank #(.K(K), .N(N)) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (task_start),
         .we       (wr_en & (wr_bank == 1'(b))),
         .waddr    (wr_idx),
         .wdata    (bus.l_out),
         .set_full (wr_last & (wr_bank == 1'(b))),
         .clr_full (rd_done & (rd_bank == 1'(b))),
         .raddr    (rd_addr),
         .rdata    (rdata[b]),
         .full     (full[b])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n || task_start) begin
         wr_bank      <= 1'b0;
         wr_idx       <= '0;
         err_overflow <= 1'b0;
      end else if (bus.l_out_valid) begin
         if (full[wr_bank]) begin
            err_overflow <= 1'b1;
         end else if (wr_idx == LAST) begin
            wr_idx  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_idx <= wr_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || task_start) begin
         rd_state    <= RD_IDLE;
         rd_bank     <= 1'b0;
         bus.m_data  <= '0;
         bus.m_valid <= 1'b0;
         bus.m_idx   <= '0;
         bus.m_last  <= 1'b0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (full[rd_bank]) begin
                  bus.m_data  <= rdata[rd_bank];
                  bus.m_idx   <= '0;
                  bus.m_last  <= 1'b0;
                  bus.m_valid <= 1'b1;
                  rd_state    <= RD_SEND;
               end
            end
            RD_SEND: begin
               if (acc) begin
                  if (bus.m_idx == LAST) begin
                     bus.m_valid <= 1'b0;
                     bus.m_last  <= 1'b0;
                     rd_bank     <= ~rd_bank;
                     rd_state    <= RD_IDLE;
                  end else begin
                     bus.m_data <= rdata[rd_bank];
                     bus.m_idx  <= rd_addr;
                     bus.m_last <= (rd_addr == LAST);
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   assign busy = (|full) | (wr_idx != '0) | bus.m_valid;
endmodule

// File: tb/tb_l_out_pingpong_buf.sv
// tb/tb_l_out_pingpong_buf.sv - directed self-checking bench for l_out_pingpong_buf (N=4 and N=32 instances)
module tb_l_out_pingpong_buf;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic task_start = 1'b0;
   logic busy4, err4, busy32, err32;
   int   ready_mode = 1;
   logic tog = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   logic [127:0] rx_data [$];
   int           rx_idx [$];
   logic         rx_last [$];
   int           rx_cyc [$];
   logic         stall_prev = 1'b0;
   logic [127:0] hold_data;
   int           hold_idx;
   logic [127:0] exp32 [32];

   l_out_pingpong_buf_if #(.K(128), .N(4))  bus4 ();
   l_out_pingpong_buf_if #(.K(128), .N(32)) bus32 ();

   l_out_pingpong_buf #(.K(128), .N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .task_start(task_start),
      .bus(bus4), .busy(busy4), .err_overflow(err4)
   );
   l_out_pingpong_buf #(.K(128), .N(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .task_start(1'b0),
      .bus(bus32), .busy(busy32), .err_overflow(err32)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      tog <= ~tog;
   end
   // ready_mode: 0 = held low, 1 = held high, 2 = toggling every cycle
   assign bus4.m_ready  = (ready_mode == 2) ? tog : (ready_mode == 1);
   assign bus32.m_ready = 1'b1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (stall_prev && bus4.m_valid) begin
         chk("hold_data", bus4.m_data, hold_data);
         chk("hold_idx", 128'(bus4.m_idx), 128'(hold_idx));
      end
      if (bus4.m_valid && bus4.m_ready) begin
         rx_data.push_back(bus4.m_data);
         rx_idx.push_back(int'(bus4.m_idx));
         rx_last.push_back(bus4.m_last);
         rx_cyc.push_back(cyc);
      end
      stall_prev = bus4.m_valid && !bus4.m_ready;
      hold_data  = bus4.m_data;
      hold_idx   = int'(bus4.m_idx);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [127:0] d);
      bus4.l_out = d;
      bus4.l_out_valid = 1'b1;
      tick();
      bus4.l_out_valid = 1'b0;
   endtask

   task automatic clear_rx();
      rx_data.delete(); rx_idx.delete(); rx_last.delete(); rx_cyc.delete();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy4; i++) tick();
      chk(tag, 128'(busy4), 128'(0));
   endtask

   task automatic check_rx(input string tag, input logic [127:0] base, input logic [127:0] step, input int n);
      chk({tag, "_count"}, 128'(rx_data.size()), 128'(n));
      for (int i = 0; i < n && i < rx_data.size(); i++) begin
         chk({tag, "_data"}, rx_data[i], base + step * 128'(i));
         chk({tag, "_idx"}, 128'(rx_idx[i]), 128'(i % 4));
         chk({tag, "_last"}, 128'(rx_last[i]), 128'((i % 4) == 3));
      end
   endtask

   initial begin
      int k;
      bus4.l_out = '0; bus4.l_out_valid = 1'b0;
      bus32.l_out = '0; bus32.l_out_valid = 1'b0;
      tick(); tick();
      chk("rst_m_valid", 128'(bus4.m_valid), 128'(0));
      chk("rst_m_data", bus4.m_data, 128'(0));
      chk("rst_m_idx", 128'(bus4.m_idx), 128'(0));
      chk("rst_m_last", 128'(bus4.m_last), 128'(0));
      chk("rst_busy", 128'(busy4), 128'(0));
      chk("rst_err", 128'(err4), 128'(0));
      rst_n = 1'b1;
      tick();

      // 1: single frame, latency from last write to first valid word
      ready_mode = 1; clear_rx();
      send4(128'h11); send4(128'h22); send4(128'h33); send4(128'h44);
      chk("s1_valid_t1", 128'(bus4.m_valid), 128'(0));
      chk("s1_busy_full", 128'(busy4), 128'(1));
      tick();
      chk("s1_valid_t2", 128'(bus4.m_valid), 128'(1));
      chk("s1_first_data", bus4.m_data, 128'h11);
      chk("s1_first_idx", 128'(bus4.m_idx), 128'(0));
      wait_idle("s1_idle", 40);
      check_rx("s1", 128'h11, 128'h11, 4);

      // 2: two frames back-to-back, one idle cycle between them
      clear_rx();
      for (int i = 0; i < 8; i++) send4(128'h201 + 128'(i));
      wait_idle("s2_idle", 60);
      check_rx("s2", 128'h201, 128'h1, 8);
      chk("s2_gap", 128'((rx_data.size() >= 5) ? rx_cyc[4] - rx_cyc[3] : -1), 128'(2));
      chk("s2_err", 128'(err4), 128'(0));

      // 3: toggling ready, third frame written once bank 0 has drained
      ready_mode = 2; clear_rx();
      for (int i = 0; i < 8; i++) send4(128'h301 + 128'(i));
      k = 0;
      while (rx_data.size() < 4 && k < 100) begin tick(); k++; end
      chk("s3_frame1_drained", 128'(rx_data.size() >= 4), 128'(1));
      for (int i = 8; i < 12; i++) send4(128'h301 + 128'(i));
      wait_idle("s3_idle", 200);
      check_rx("s3", 128'h301, 128'h1, 12);
      chk("s3_err", 128'(err4), 128'(0));

      // 4: no ready, nine words: both banks fill, ninth is dropped
      ready_mode = 0; clear_rx();
      for (int i = 0; i < 9; i++) send4(128'h401 + 128'(i));
      tick(); tick();
      chk("s4_err_set", 128'(err4), 128'(1));
      chk("s4_stall_valid", 128'(bus4.m_valid), 128'(1));
      chk("s4_stall_data", bus4.m_data, 128'h401);
      ready_mode = 1;
      wait_idle("s4_idle", 60);
      check_rx("s4", 128'h401, 128'h1, 8);
      chk("s4_err_held", 128'(err4), 128'(1));
      task_start = 1'b1; tick(); task_start = 1'b0;
      chk("s4_err_cleared", 128'(err4), 128'(0));

      // 5: task_start abandons a partial frame and drops the word in its cycle
      clear_rx();
      send4(128'h51); send4(128'h52);
      task_start = 1'b1; bus4.l_out = 128'hEE; bus4.l_out_valid = 1'b1;
      tick();
      task_start = 1'b0; bus4.l_out_valid = 1'b0;
      chk("s5_busy_cleared", 128'(busy4), 128'(0));
      for (int i = 0; i < 4; i++) send4(128'hA0 + 128'(i));
      wait_idle("s5_idle", 40);
      check_rx("s5", 128'hA0, 128'h1, 4);

      // 6: reset mid-drain
      clear_rx();
      for (int i = 0; i < 4; i++) send4(128'h61 + 128'(i));
      k = 0;
      while (!(bus4.m_valid && bus4.m_idx == 2) && k < 20) begin tick(); k++; end
      chk("s6_reached_idx2", 128'(bus4.m_idx), 128'(2));
      ready_mode = 0; rst_n = 1'b0;
      tick();
      chk("s6_m_valid", 128'(bus4.m_valid), 128'(0));
      chk("s6_m_data", bus4.m_data, 128'(0));
      chk("s6_m_idx", 128'(bus4.m_idx), 128'(0));
      chk("s6_m_last", 128'(bus4.m_last), 128'(0));
      chk("s6_busy", 128'(busy4), 128'(0));
      chk("s6_err", 128'(err4), 128'(0));
      rst_n = 1'b1; ready_mode = 1; clear_rx();
      repeat (6) tick();
      chk("s6_no_residual", 128'(rx_data.size()), 128'(0));

      // N=32: random frame replayed bit-exact
      for (int i = 0; i < 32; i++) begin
         exp32[i] = {$urandom, $urandom, $urandom, $urandom};
         bus32.l_out = exp32[i];
         bus32.l_out_valid = 1'b1;
         tick();
      end
      bus32.l_out_valid = 1'b0;
      chk("n32_valid_t1", 128'(bus32.m_valid), 128'(0));
      tick();
      for (int i = 0; i < 32; i++) begin
         chk("n32_valid", 128'(bus32.m_valid), 128'(1));
         chk("n32_data", bus32.m_data, exp32[i]);
         chk("n32_idx", 128'(bus32.m_idx), 128'(i));
         chk("n32_last", 128'(bus32.m_last), 128'(i == 31));
         tick();
      end
      chk("n32_done", 128'(busy32), 128'(0));
      chk("n32_err", 128'(err32), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
